// File: rtl/axil2wb_master_if.sv
// Bus bundle for the AXI-Lite to Wishbone bridge.
// "slave" is the bridge's view (AXI-Lite slave side plus Wishbone master side);
// "master" is the environment's view (AXI initiator plus Wishbone slave).
interface axil2wb_master_if #(
  parameter int ADDR_W = 12
);
  logic              awvalid, awready;
  logic [ADDR_W-1:0] awaddr;
  logic              wvalid, wready;
  logic [31:0]       wdata;
  logic [3:0]        wstrb;
  logic              bvalid, bready;
  logic [1:0]        bresp;
  logic              arvalid, arready;
  logic [ADDR_W-1:0] araddr;
  logic              rvalid, rready;
  logic [31:0]       rdata;
  logic [1:0]        rresp;
  logic              wbm_cyc_o, wbm_stb_o, wbm_we_o;
  logic [3:0]        wbm_sel_o;
  logic [31:0]       wbm_adr_o, wbm_dat_o;
  logic [31:0]       wbm_dat_i;
  logic              wbm_ack_i;

  modport slave (
    input  awvalid, awaddr, wvalid, wdata, wstrb, bready,
           arvalid, araddr, rready, wbm_dat_i, wbm_ack_i,
    output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp,
           wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o
  );

  modport master (
    output awvalid, awaddr, wvalid, wdata, wstrb, bready,
           arvalid, araddr, rready, wbm_dat_i, wbm_ack_i,
    input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp,
           wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o
  );
endinterface

// File: rtl/axil2wb_master.sv
// AXI4-Lite slave to classic Wishbone master bridge.
// One access in flight; writes win over reads; a watchdog turns a missing
// Wishbone ack into SLVERR so the AXI side always gets a response.
module axil2wb_master #(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter int          ADDR_W    = 12,
  parameter int          TIMEOUT   = 255
) (
  input  logic                     wb_clk_i,
  input  logic                     wb_rst_i,
  axil2wb_master_if.slave          bus
);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {IDLE, WB_WR, WB_RD, B_RESP, R_RESP} state_t;

  state_t            state;
  logic              aw_held, w_held;
  logic [ADDR_W-1:0] aw_addr_q;
  logic [31:0]       w_data_q;
  logic [3:0]        w_strb_q;
  logic [9:0]        wd_cnt;

  logic              cyc_q, we_q;
  logic [3:0]        sel_q;
  logic [31:0]       adr_q, dat_q;
  logic              bvalid_q, rvalid_q;
  logic [1:0]        bresp_q, rresp_q;
  logic [31:0]       rdata_q;

  logic              idle, aw_hs, w_hs, ar_hs, aw_have, w_have, wd_last;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;
  logic [3:0]        wr_strb;

  // Readies come straight from registered state so they drop the instant
  // reset asserts; arready also backs off while any write channel is active.
  assign idle        = (state == IDLE);
  assign bus.awready = idle & ~aw_held & ~wb_rst_i;
  assign bus.wready  = idle & ~w_held & ~wb_rst_i;
  assign bus.arready = idle & ~aw_held & ~w_held & ~bus.awvalid & ~bus.wvalid & ~wb_rst_i;

  assign aw_hs   = bus.awvalid & bus.awready;
  assign w_hs    = bus.wvalid & bus.wready;
  assign ar_hs   = bus.arvalid & bus.arready;
  assign aw_have = aw_held | aw_hs;
  assign w_have  = w_held | w_hs;

  // Payload for the launch cycle: a channel arriving this cycle bypasses its latch.
  assign wr_addr = aw_held ? aw_addr_q : bus.awaddr;
  assign wr_data = w_held ? w_data_q : bus.wdata;
  assign wr_strb = w_held ? w_strb_q : bus.wstrb;

  // Counter holds the number of completed un-acked cycles, so this is the last one.
  assign wd_last = (wd_cnt == 10'(TIMEOUT - 1));

  assign bus.wbm_cyc_o = cyc_q;
  assign bus.wbm_stb_o = cyc_q;
  assign bus.wbm_we_o  = we_q;
  assign bus.wbm_sel_o = sel_q;
  assign bus.wbm_adr_o = adr_q;
  assign bus.wbm_dat_o = dat_q;
  assign bus.bvalid    = bvalid_q;
  assign bus.bresp     = bresp_q;
  assign bus.rvalid    = rvalid_q;
  assign bus.rresp     = rresp_q;
  assign bus.rdata     = rdata_q;

  // Bridge FSM: capture AXI request, run one Wishbone cycle, return the response.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state     <= IDLE;
      aw_held   <= 1'b0;
      w_held    <= 1'b0;
      aw_addr_q <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      wd_cnt    <= '0;
      cyc_q     <= 1'b0;
      we_q      <= 1'b0;
      sel_q     <= '0;
      adr_q     <= '0;
      dat_q     <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= '0;
      rvalid_q  <= 1'b0;
      rresp_q   <= '0;
      rdata_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (aw_hs) begin
            aw_held   <= 1'b1;
            aw_addr_q <= bus.awaddr;
          end
          if (w_hs) begin
            w_held   <= 1'b1;
            w_data_q <= bus.wdata;
            w_strb_q <= bus.wstrb;
          end
          if (aw_have && w_have) begin
            aw_held <= 1'b0;
            w_held  <= 1'b0;
            adr_q   <= BASE_ADDR | 32'(wr_addr[ADDR_W-1:0]);
            we_q    <= 1'b1;
            sel_q   <= wr_strb;
            dat_q   <= wr_data;
            cyc_q   <= 1'b1;
            wd_cnt  <= '0;
            state   <= WB_WR;
          end else if (ar_hs) begin
            adr_q  <= BASE_ADDR | 32'(bus.araddr[ADDR_W-1:0]);
            we_q   <= 1'b0;
            sel_q  <= 4'hF;
            cyc_q  <= 1'b1;
            wd_cnt <= '0;
            state  <= WB_RD;
          end
        end
        WB_WR, WB_RD: begin
          // Ack beats the watchdog when both land in the same cycle.
          if (bus.wbm_ack_i || wd_last) begin
            cyc_q <= 1'b0;
            we_q  <= 1'b0;
            if (state == WB_WR) begin
              bvalid_q <= 1'b1;
              bresp_q  <= bus.wbm_ack_i ? RESP_OKAY : RESP_SLVERR;
              state    <= B_RESP;
            end else begin
              rvalid_q <= 1'b1;
              rresp_q  <= bus.wbm_ack_i ? RESP_OKAY : RESP_SLVERR;
              rdata_q  <= bus.wbm_ack_i ? bus.wbm_dat_i : 32'h0;
              state    <= R_RESP;
            end
          end else begin
            wd_cnt <= wd_cnt + 10'd1;
          end
        end
        B_RESP: begin
          if (bus.bready) begin
            bvalid_q <= 1'b0;
            state    <= IDLE;
          end
        end
        R_RESP: begin
          if (bus.rready) begin
            rvalid_q <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axil2wb_master.sv
// Scoreboard bench for axil2wb_master: expected Wishbone requests and AXI
// responses are queued as stimulus is issued and retired by a monitor.
module tb_axil2wb_master;
  localparam int          TO   = 8;
  localparam logic [31:0] BASE = 32'h3000_0000;

  logic wb_clk_i = 1'b0;
  logic wb_rst_i = 1'b1;
  always #5 wb_clk_i = ~wb_clk_i;

  axil2wb_master_if #(.ADDR_W(12)) bus ();

  axil2wb_master #(.BASE_ADDR(BASE), .ADDR_W(12), .TIMEOUT(TO)) dut (
    .wb_clk_i (wb_clk_i),
    .wb_rst_i (wb_rst_i),
    .bus      (bus)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  typedef struct { logic we; logic [31:0] adr; logic [3:0] sel; logic [31:0] dat; } wb_exp_t;
  typedef struct { logic rd; logic [1:0] resp; logic [31:0] data; } rsp_exp_t;
  wb_exp_t  wb_q[$];
  rsp_exp_t rsp_q[$];

  task automatic exp_wb(input logic we, input logic [11:0] a, input logic [3:0] s, input logic [31:0] d);
    wb_exp_t e;
    e.we = we; e.adr = BASE | {20'h0, a}; e.sel = s; e.dat = d;
    wb_q.push_back(e);
  endtask

  task automatic exp_rsp(input logic rd, input logic [1:0] r, input logic [31:0] d);
    rsp_exp_t e;
    e.rd = rd; e.resp = r; e.data = d;
    rsp_q.push_back(e);
  endtask

  // Wishbone slave model: ack in cycle ack_at of the cycle (0 = never).
  int          ack_at  = 2;
  logic        stray   = 1'b0;
  logic [31:0] rd_data = 32'h0;
  int          s_cnt   = 0;
  always @(negedge wb_clk_i) begin
    if (bus.wbm_cyc_o) s_cnt++;
    else s_cnt = 0;
    bus.wbm_ack_i = stray | (bus.wbm_cyc_o && ack_at != 0 && s_cnt == ack_at);
    bus.wbm_dat_i = rd_data;
  end

  int cyc_n = 0;
  always @(posedge wb_clk_i) cyc_n++;

  // Monitor: samples late in each cycle, after drivers have settled.
  logic        cyc_p = 1'b0, bv_p = 1'b0, rv_p = 1'b0;
  logic [31:0] rd_p  = '0;
  logic [1:0]  rr_p  = '0;
  int          cyc_len = 0, cyc_last = -10, exp_len = 0, ar_hs = 0, b_hs = 0;
  wb_exp_t     mw;
  rsp_exp_t    mr;
  always @(negedge wb_clk_i) begin
    #3;
    if (bus.wbm_cyc_o && !cyc_p) begin
      cyc_len = 0;
      if (wb_q.size() == 0) chk("wb_unexpected", 1, 0);
      else begin
        mw = wb_q.pop_front();
        chk("wb_we", bus.wbm_we_o, mw.we);
        chk("wb_adr", bus.wbm_adr_o, mw.adr);
        chk("wb_sel", bus.wbm_sel_o, mw.sel);
        chk("wb_stb", bus.wbm_stb_o, 1);
        if (mw.we) chk("wb_dat", bus.wbm_dat_o, mw.dat);
      end
    end
    if (bus.wbm_cyc_o) begin
      cyc_len++;
      cyc_last = cyc_n;
    end
    if (!bus.wbm_cyc_o && cyc_p && exp_len != 0) chk("cyc_len", cyc_len, exp_len);
    if ((bus.bvalid && !bv_p) || (bus.rvalid && !rv_p)) chk("rsp_lat", cyc_n - cyc_last, 1);
    if (bus.rvalid && rv_p) begin
      chk("rdata_stable", bus.rdata, rd_p);
      chk("rresp_stable", bus.rresp, rr_p);
    end
    if (bus.bvalid && bus.bready) begin
      b_hs = cyc_n + 1;
      if (rsp_q.size() == 0) chk("b_unexpected", 1, 0);
      else begin
        mr = rsp_q.pop_front();
        chk("b_kind", 0, mr.rd);
        chk("bresp", bus.bresp, mr.resp);
      end
    end
    if (bus.rvalid && bus.rready) begin
      if (rsp_q.size() == 0) chk("r_unexpected", 1, 0);
      else begin
        mr = rsp_q.pop_front();
        chk("r_kind", 1, mr.rd);
        chk("rresp", bus.rresp, mr.resp);
        chk("rdata", bus.rdata, mr.data);
      end
    end
    if (bus.arvalid && bus.arready) ar_hs = cyc_n + 1;
    cyc_p = bus.wbm_cyc_o;
    bv_p  = bus.bvalid;
    rv_p  = bus.rvalid;
    rd_p  = bus.rdata;
    rr_p  = bus.rresp;
  end

  // Drive AW and W; W is presented first, AW 'lead' cycles later.
  task automatic send_wr(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s, input int lead);
    logic aw_go, w_go, aw_done, w_done;
    int   i;
    aw_go = 0; w_go = 0; aw_done = 0; w_done = 0; i = 0;
    while (!(aw_done && w_done) && i < 50) begin
      @(negedge wb_clk_i);
      if (aw_go) begin bus.awvalid = 0; aw_done = 1; aw_go = 0; end
      if (w_go)  begin bus.wvalid = 0;  w_done = 1;  w_go = 0;  end
      if (i == 0) begin bus.wvalid = 1; bus.wdata = d; bus.wstrb = s; end
      if (i == lead) begin bus.awvalid = 1; bus.awaddr = a; end
      #1;
      aw_go = bus.awvalid && bus.awready;
      w_go  = bus.wvalid && bus.wready;
      i++;
    end
    if (!(aw_done && w_done)) begin
      chk("wr_hs_timeout", 0, 1);
      bus.awvalid = 0; bus.wvalid = 0;
    end
  endtask

  task automatic send_rd(input logic [11:0] a);
    logic go, done;
    int   i;
    go = 0; done = 0; i = 0;
    while (!done && i < 100) begin
      @(negedge wb_clk_i);
      if (go) begin bus.arvalid = 0; done = 1; end
      else begin
        bus.arvalid = 1; bus.araddr = a;
        #1;
        go = bus.arready;
      end
      i++;
    end
    if (!done) begin
      chk("rd_hs_timeout", 0, 1);
      bus.arvalid = 0;
    end
  endtask

  // Wait for a response, hold ready low 'hold' cycles, then take it.
  task automatic wait_rsp(input logic rd, input int hold);
    logic seen;
    seen = 0;
    for (int i = 0; i < 400 && !seen; i++) begin
      @(negedge wb_clk_i);
      #1;
      seen = rd ? bus.rvalid : bus.bvalid;
    end
    if (!seen) begin
      chk(rd ? "r_timeout" : "b_timeout", 0, 1);
      return;
    end
    repeat (hold) @(negedge wb_clk_i);
    if (rd) bus.rready = 1; else bus.bready = 1;
    @(negedge wb_clk_i);
    bus.rready = 0;
    bus.bready = 0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_rdy"}, {bus.awready, bus.wready, bus.arready}, 0);
    chk({tag, "_ctl"}, {bus.wbm_cyc_o, bus.wbm_stb_o, bus.wbm_we_o, bus.bvalid, bus.rvalid}, 0);
    chk({tag, "_resp"}, {bus.bresp, bus.rresp, bus.wbm_sel_o}, 0);
    chk({tag, "_adr"}, bus.wbm_adr_o, 0);
    chk({tag, "_dat"}, bus.wbm_dat_o, 0);
    chk({tag, "_rdata"}, bus.rdata, 0);
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench time limit");
  end

  initial begin
    bus.awvalid = 0; bus.awaddr = '0; bus.wvalid = 0; bus.wdata = '0; bus.wstrb = '0;
    bus.bready = 0; bus.arvalid = 0; bus.araddr = '0; bus.rready = 0;

    // Reset state and ready release
    repeat (3) @(negedge wb_clk_i);
    #1;
    check_reset_outputs("rst");
    @(negedge wb_clk_i);
    wb_rst_i = 0;
    #1;
    chk("rdy_after_rst", {bus.awready, bus.wready, bus.arready}, 3'b111);

    // Single write, AW and W together, ack in cycle 2
    ack_at = 2; exp_len = 2;
    exp_wb(1, 12'h010, 4'hF, 32'h0000_0005);
    exp_rsp(0, 2'b00, 0);
    send_wr(12'h010, 32'h0000_0005, 4'hF, 0);
    wait_rsp(0, 0);

    // W three cycles ahead of AW, read pending throughout
    rd_data = 32'hCAFE_0001;
    exp_wb(1, 12'h080, 4'b0011, 32'hDEAD_BEEF);
    exp_rsp(0, 2'b00, 0);
    exp_wb(0, 12'h0C0, 4'hF, 0);
    exp_rsp(1, 2'b00, 32'hCAFE_0001);
    fork
      begin send_wr(12'h080, 32'hDEAD_BEEF, 4'b0011, 3); wait_rsp(0, 0); end
      send_rd(12'h0C0);
    join
    wait_rsp(1, 0);
    chk("ar_after_b", ar_hs - b_hs, 1);

    // Plain read, then a read with rready held off
    rd_data = 32'h0000_0004;
    exp_wb(0, 12'h000, 4'hF, 0);
    exp_rsp(1, 2'b00, 32'h0000_0004);
    send_rd(12'h000);
    wait_rsp(1, 0);
    rd_data = 32'hA5A5_0004;
    exp_wb(0, 12'h004, 4'hF, 0);
    exp_rsp(1, 2'b00, 32'hA5A5_0004);
    send_rd(12'h004);
    wait_rsp(1, 5);

    // Read timeout, then a minimum-latency write
    ack_at = 0; exp_len = TO; rd_data = 32'hBAD0_BAD0;
    exp_wb(0, 12'h040, 4'hF, 0);
    exp_rsp(1, 2'b10, 32'h0);
    send_rd(12'h040);
    wait_rsp(1, 0);
    ack_at = 1; exp_len = 1;
    exp_wb(1, 12'h044, 4'hF, 32'h11);
    exp_rsp(0, 2'b00, 0);
    send_wr(12'h044, 32'h11, 4'hF, 0);
    wait_rsp(0, 0);

    // Ack on the last watchdog cycle wins; write timeout gives SLVERR
    ack_at = TO; exp_len = TO; rd_data = 32'h1357_9BDF;
    exp_wb(0, 12'h048, 4'hF, 0);
    exp_rsp(1, 2'b00, 32'h1357_9BDF);
    send_rd(12'h048);
    wait_rsp(1, 0);
    ack_at = 0; exp_len = TO;
    exp_wb(1, 12'h04C, 4'h1, 32'h22);
    exp_rsp(0, 2'b10, 0);
    send_wr(12'h04C, 32'h22, 4'h1, 0);
    wait_rsp(0, 0);

    // Stray ack while idle is ignored
    @(negedge wb_clk_i); stray = 1;
    @(negedge wb_clk_i); stray = 0;
    repeat (2) @(negedge wb_clk_i);
    #1;
    chk("stray_ack", {bus.bvalid, bus.rvalid, bus.wbm_cyc_o}, 0);

    // Reset while cyc is high, then a clean write
    ack_at = 0; exp_len = 0;
    exp_wb(1, 12'h050, 4'hF, 32'h77);
    send_wr(12'h050, 32'h77, 4'hF, 0);
    repeat (3) @(negedge wb_clk_i);
    #1;
    chk("cyc_before_rst", bus.wbm_cyc_o, 1);
    #1;
    wb_rst_i = 1;
    #1;
    check_reset_outputs("mid_rst");
    @(negedge wb_clk_i);
    wb_rst_i = 0;
    repeat (3) @(negedge wb_clk_i);
    #1;
    chk("no_stale_rsp", {bus.bvalid, bus.rvalid, bus.wbm_cyc_o}, 0);
    ack_at = 2; exp_len = 2;
    exp_wb(1, 12'h054, 4'hC, 32'h99);
    exp_rsp(0, 2'b00, 0);
    send_wr(12'h054, 32'h99, 4'hC, 0);
    wait_rsp(0, 0);

    repeat (3) @(negedge wb_clk_i);
    chk("sb_drained", wb_q.size() + rsp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/axil2wb_master.md
# axil2wb_master

AXI4-Lite slave to Wishbone master bridge for the user-project address space. It accepts single-beat AXI-Lite reads and writes from an upstream initiator, such as a firmware-side DMA or a test driver. Each access is replayed as one classic Wishbone cycle toward the user-area slaves at 0x3000_0000, and the AXI response is returned. A per-access watchdog converts a missing Wishbone ack into an AXI SLVERR, so the initiator can never hang.

## Interface
- BASE_ADDR, 32'h3000_0000: OR-ed onto the captured AXI address to form wbm_adr_o.
- ADDR_W, 12: number of AXI address bits used; bits above ADDR_W-1 are ignored.
- TIMEOUT, 255: Wishbone cycles without ack before abort; legal range 1..1023.
- wb_clk_i  in  1  clock; all logic is rising-edge.
- wb_rst_i  in  1  reset, asynchronous, active-high.
- awvalid/awready  in/out  1  write-address handshake.
- awaddr  in  ADDR_W  write address.
- wvalid/wready  in/out  1  write-data handshake.
- wdata  in  32  write data.
- wstrb  in  4  byte strobes.
- bvalid/bready  out/in  1  write-response handshake.
- bresp  out  2  write response: 2'b00 OKAY, 2'b10 SLVERR.
- arvalid/arready  in/out  1  read-address handshake.
- araddr  in  ADDR_W  read address.
- rvalid/rready  out/in  1  read-data handshake.
- rdata  out  32  read data.
- rresp  out  2  read response, encoded as for bresp.
- wbm_cyc_o, wbm_stb_o  out  1  Wishbone cycle and strobe; always driven equal.
- wbm_we_o  out  1  Wishbone write enable.
- wbm_sel_o  out  4  Wishbone byte selects.
- wbm_adr_o  out  32  Wishbone address.
- wbm_dat_o  out  32  Wishbone write data.
- wbm_dat_i  in  32  Wishbone read data.
- wbm_ack_i  in  1  Wishbone acknowledge.

## Operation
- The state machine has five states: IDLE, WB_WR, WB_RD, B_RESP, R_RESP. Only one transaction is outstanding at a time.
- IDLE write capture:
  - awready = ~aw_held, wready = ~w_held; both are held low while wb_rst_i is high.
  - AW and W may complete in either order or in the same cycle. Each sets its held flag and latches its payload.
- IDLE read capture: arready = ~aw_held & ~w_held & ~awvalid & ~wvalid. A pending or partial write therefore blocks reads.
- Arbitration: write has fixed priority. A read is accepted only when no write channel is active.
- IDLE -> WB_WR when aw_held & w_held:
  - wbm_adr_o = BASE_ADDR | awaddr.
  - wbm_we_o = 1, wbm_sel_o = wstrb, wbm_dat_o = wdata.
  - cyc/stb are asserted.
  - Held flags clear on entry.
- IDLE -> WB_RD on the AR handshake: wbm_adr_o = BASE_ADDR | araddr, wbm_we_o = 0, wbm_sel_o = 4'hF.
- WB_WR/WB_RD on wbm_ack_i:
  - Deassert cyc/stb in the next cycle.
  - Move to B_RESP (resp OKAY), or to R_RESP (rdata = wbm_dat_i, latched on the ack edge, resp OKAY).
- Watchdog:
  - A 10-bit counter clears on entry to WB_WR/WB_RD and increments each cycle cyc is high without ack.
  - When the count reaches TIMEOUT with no ack: drop cyc/stb and move to the response state with resp 2'b10. rdata = 0 for reads.
  - An ack in the same cycle the count reaches TIMEOUT wins, giving OKAY.
- B_RESP: bvalid = 1 until bready; then go to IDLE.
- R_RESP: rvalid = 1 until rready; then go to IDLE. rdata/rresp stay stable while rvalid is high.
- A wbm_ack_i outside WB_WR/WB_RD is ignored.
- Reset mid-operation:
  - The transaction is abandoned; the state machine returns to IDLE and held flags clear.
  - The abandoned transaction gets no response after reset.

## Timing
- Reset values: awready = wready = arready = 0 while wb_rst_i is high. bvalid, rvalid, wbm_cyc_o, wbm_stb_o, wbm_we_o = 0. bresp, rresp, rdata, wbm_adr_o, wbm_dat_o, wbm_sel_o = 0.
- Readies rise in the first cycle after wb_rst_i falls.
- All outputs except the readies are registered. The readies are combinational from registered flags and state, plus awvalid/wvalid for arready.
- Write latency: AW+W handshake at edge N -> cyc high from N+1 -> ack at edge M -> cyc low and bvalid high from M+1.
- The minimum with a same-cycle ack (ack at N+1) is bvalid in cycle N+2.
- Read latency is the same: AR at N -> cyc N+1 -> ack at M -> rvalid M+1.
- Timeout: with no ack, cyc stays high for exactly TIMEOUT cycles, then bvalid/rvalid is asserted the next cycle.
- Back-to-back: the next AW/W/AR can be accepted in the cycle after the B/R handshake.

## Test plan
- Single write:
  - Stimulus: AW 0x010 and W 0x0000_0005 with wstrb F in the same cycle; slave acks in its 2nd cycle.
  - Required: wbm_adr_o = 0x3000_0010, we = 1, sel = F, dat = 5; bresp 00 exactly one cycle after the ack cycle.
- Order independence:
  - Stimulus: W 0xDEAD_BEEF (wstrb 4'b0011) three cycles before AW 0x080.
  - Required: one Wishbone write to 0x3000_0080 with sel 3; arvalid held high throughout is not accepted until bready completes.
- Read:
  - Stimulus: AR 0x000; slave returns 0x0000_0004 with ack.
  - Required: rdata = 4, rresp 00.
  - Repeat with rready held low for 5 cycles: rvalid and rdata stay stable.
- Timeout (TIMEOUT = 8):
  - Stimulus: read 0x040 with no ack.
  - Required: cyc high for exactly 8 cycles, then rresp 10, rdata 0.
  - A following write with a normal ack completes OKAY.
- Ack at the timeout boundary:
  - Stimulus: ack arrives in the 8th cycle.
  - Required: OKAY response with the slave's data.
- Reset mid-cycle:
  - Stimulus: assert wb_rst_i while cyc is high.
  - Required: all outputs go to their reset values asynchronously; after release, a new write completes normally and no stale bvalid appears.
